// File: rtl/raycast_pkg.sv
// Shared constants, pixel type and shading helper for the ray-cast column path.
package raycast_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 180;
    localparam int unsigned PIXEL_WIDTH   = 16;
    localparam int unsigned COL_W         = 9;
    localparam int unsigned ROW_W         = 8;
    localparam int unsigned ADDR_W        = 16;

    localparam logic [PIXEL_WIDTH-1:0] CEILING_COLOR = 16'h18E3;
    localparam logic [PIXEL_WIDTH-1:0] FLOOR_COLOR   = 16'h4208;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } flat_state_t;

    // Halve each colour field independently so no bit bleeds between fields.
    function automatic rgb565_t shade565(input rgb565_t c);
        rgb565_t s;
        s.r = c.r >> 1;
        s.g = c.g >> 1;
        s.b = c.b >> 1;
        return s;
    endfunction

endpackage

// File: rtl/column_span_calc.sv
// Vertical wall span for one column: clamped height, first/last wall row, empty flag.
module column_span_calc
    import raycast_pkg::*;
(
    input  logic [ROW_W-1:0] line_height,
    output logic [ROW_W-1:0] span_start_c,
    output logic [ROW_W-1:0] span_end_c,
    output logic             span_empty_c
);

    logic [ROW_W-1:0] height_clamped;

    // Walls taller than the screen fill every row.
    always_comb begin
        height_clamped = line_height;
        if (line_height > ROW_W'(SCREEN_HEIGHT)) begin
            height_clamped = ROW_W'(SCREEN_HEIGHT);
        end
    end

    // Centre the span; odd leftovers put the extra row below the wall.
    assign span_start_c = (ROW_W'(SCREEN_HEIGHT) - height_clamped) >> 1;
    assign span_end_c   = span_start_c + height_clamped - ROW_W'(1);
    assign span_empty_c = (height_clamped == '0);

endmodule

// File: rtl/column_flattener.sv
// Expands column descriptors into per-row RGB565 frame_buffer writes.
module column_flattener
    import raycast_pkg::*;
(
    input  logic                   pixel_clk_in,
    input  logic                   rst_n_in,
    input  logic                   col_valid_in,
    output logic                   col_ready_out,
    input  logic [COL_W-1:0]       col_index_in,
    input  logic [ROW_W-1:0]       line_height_in,
    input  logic [PIXEL_WIDTH-1:0] wall_color_in,
    input  logic                   side_in,
    input  logic                   col_last_in,
    output logic [ADDR_W-1:0]      ray_address_out,
    output logic [PIXEL_WIDTH-1:0] ray_pixel_out,
    output logic                   ray_valid_out,
    output logic                   ray_last_pixel_out
);

    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(SCREEN_HEIGHT - 1);
    localparam logic [ROW_W-1:0] PRE_LAST_ROW = ROW_W'(SCREEN_HEIGHT - 2);

    flat_state_t            state;
    logic [ROW_W-1:0]       row_cnt;
    logic [ADDR_W-1:0]      addr_acc;
    logic [PIXEL_WIDTH-1:0] col_wall;
    logic [ROW_W-1:0]       span_start_q;
    logic [ROW_W-1:0]       span_end_q;
    logic                   span_empty_q;
    logic                   col_last_q;
    logic                   oor_last_pend;

    logic [ROW_W-1:0]       span_start_c;
    logic [ROW_W-1:0]       span_end_c;
    logic                   span_empty_c;
    logic                   accept_c;
    logic                   in_range_c;
    logic [PIXEL_WIDTH-1:0] wall_shaded_c;
    logic [PIXEL_WIDTH-1:0] row_pixel_c;

    column_span_calc u_span (
        .line_height  (line_height_in),
        .span_start_c (span_start_c),
        .span_end_c   (span_end_c),
        .span_empty_c (span_empty_c)
    );

    assign accept_c      = col_valid_in && col_ready_out;
    assign in_range_c    = (col_index_in < COL_W'(SCREEN_WIDTH));
    assign wall_shaded_c = side_in ? PIXEL_WIDTH'(shade565(rgb565_t'(wall_color_in)))
                                   : wall_color_in;

    // Ceiling above the span, wall inside it, floor below (or everywhere past start when empty).
    always_comb begin
        row_pixel_c = FLOOR_COLOR;
        if (row_cnt < span_start_q) begin
            row_pixel_c = CEILING_COLOR;
        end else if (!span_empty_q && (row_cnt <= span_end_q)) begin
            row_pixel_c = col_wall;
        end
    end

    // Control FSM, row counter, address accumulator and registered outputs.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            state              <= ST_IDLE;
            row_cnt            <= '0;
            addr_acc           <= '0;
            col_wall           <= '0;
            span_start_q       <= '0;
            span_end_q         <= '0;
            span_empty_q       <= 1'b0;
            col_last_q         <= 1'b0;
            oor_last_pend      <= 1'b0;
            col_ready_out      <= 1'b1;
            ray_address_out    <= '0;
            ray_pixel_out      <= '0;
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= 1'b0;
        end else begin
            ray_valid_out      <= 1'b0;
            ray_last_pixel_out <= oor_last_pend;
            oor_last_pend      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    col_ready_out <= 1'b1;
                end
                ST_DRAW: begin
                    ray_address_out <= addr_acc;
                    ray_pixel_out   <= row_pixel_c;
                    ray_valid_out   <= 1'b1;
                    addr_acc        <= addr_acc + ADDR_W'(SCREEN_WIDTH);
                    row_cnt         <= row_cnt + ROW_W'(1);
                    if (row_cnt == LAST_ROW) begin
                        ray_last_pixel_out <= col_last_q | oor_last_pend;
                        state              <= ST_IDLE;
                        col_ready_out      <= 1'b1;
                    end else if (row_cnt == PRE_LAST_ROW) begin
                        // Open the window one cycle early so the next column follows without a bubble.
                        col_ready_out <= 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    col_ready_out <= 1'b1;
                end
            endcase

            // Accept overrides the end-of-column return to IDLE for back-to-back streaming.
            if (accept_c) begin
                if (in_range_c) begin
                    state         <= ST_DRAW;
                    row_cnt       <= '0;
                    addr_acc      <= ADDR_W'(col_index_in);
                    col_wall      <= wall_shaded_c;
                    span_start_q  <= span_start_c;
                    span_end_q    <= span_end_c;
                    span_empty_q  <= span_empty_c;
                    col_last_q    <= col_last_in;
                    col_ready_out <= 1'b0;
                end else begin
                    oor_last_pend <= col_last_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_column_flattener.sv
// Scoreboard bench for column_flattener: reference model queues expected writes at accept.
module tb_column_flattener;

    localparam int SW = 320;
    localparam int SH = 180;

    logic        pixel_clk_in = 1'b0;
    logic        rst_n_in;
    logic        col_valid_in;
    logic        col_ready_out;
    logic [8:0]  col_index_in;
    logic [7:0]  line_height_in;
    logic [15:0] wall_color_in;
    logic        side_in;
    logic        col_last_in;
    logic [15:0] ray_address_out;
    logic [15:0] ray_pixel_out;
    logic        ray_valid_out;
    logic        ray_last_pixel_out;

    typedef struct packed {
        logic        v;
        logic        l;
        logic [15:0] a;
        logic [15:0] p;
        logic [7:0]  row;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] mdl_addr = '0;
    logic [15:0] mdl_pix  = '0;
    int          run_len  = 0;
    int          last_run = 0;

    column_flattener dut (
        .pixel_clk_in       (pixel_clk_in),
        .rst_n_in           (rst_n_in),
        .col_valid_in       (col_valid_in),
        .col_ready_out      (col_ready_out),
        .col_index_in       (col_index_in),
        .line_height_in     (line_height_in),
        .wall_color_in      (wall_color_in),
        .side_in            (side_in),
        .col_last_in        (col_last_in),
        .ray_address_out    (ray_address_out),
        .ray_pixel_out      (ray_pixel_out),
        .ray_valid_out      (ray_valid_out),
        .ray_last_pixel_out (ray_last_pixel_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: build the full expected write list for one descriptor.
    task automatic push_col(input int col, input int h, input logic [15:0] wall,
                            input bit side, input bit last);
        int          hh;
        int          st;
        logic [15:0] ws;
        logic [15:0] pix;
        logic [15:0] a;
        exp_t        e;
        if (col >= SW) begin
            if (last) begin
                e = '{v: 1'b0, l: 1'b1, a: mdl_addr, p: mdl_pix, row: 8'd0};
                sb.push_back(e);
            end
            return;
        end
        hh = (h > SH) ? SH : h;
        st = (SH - hh) / 2;
        ws = side ? {1'b0, wall[15:12], 1'b0, wall[10:6], 1'b0, wall[4:1]} : wall;
        for (int r = 0; r < SH; r++) begin
            if (r < st)                         pix = 16'h18E3;
            else if (hh != 0 && r < st + hh)    pix = ws;
            else                                pix = 16'h4208;
            a = 16'(col + SW * r);
            e = '{v: 1'b1, l: (r == SH - 1) && last, a: a, p: pix, row: 8'(r)};
            sb.push_back(e);
            mdl_addr = a;
            mdl_pix  = pix;
        end
    endtask

    // Output monitor: every write or last pulse must match the head of the scoreboard.
    always @(negedge pixel_clk_in) begin
        exp_t e;
        if (rst_n_in) begin
            if (ray_valid_out) run_len++;
            else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (ray_valid_out || ray_last_pixel_out) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", {30'd0, ray_valid_out, ray_last_pixel_out,
                             ray_address_out, ray_pixel_out}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("pixel", {30'd0, ray_valid_out, ray_last_pixel_out,
                             ray_address_out, ray_pixel_out}, {30'd0, e.v, e.l, e.a, e.p});
                    if (e.v && e.row != 8'(SH - 1))
                        check_eq("ready_window", 64'(col_ready_out), 64'(e.row == 8'(SH - 2)));
                end
            end
        end
    end

    task automatic send_col(input int col, input int h, input logic [15:0] wall,
                            input bit side, input bit last);
        int budget = 0;
        @(negedge pixel_clk_in);
        col_valid_in   = 1'b1;
        col_index_in   = 9'(col);
        line_height_in = 8'(h);
        wall_color_in  = wall;
        side_in        = side;
        col_last_in    = last;
        while (!col_ready_out && budget < 1000) begin
            @(negedge pixel_clk_in);
            budget++;
        end
        if (!col_ready_out) begin
            check_eq("accept_timeout", 64'd0, 64'd1);
            col_valid_in = 1'b0;
            return;
        end
        push_col(col, h, wall, side, last);
        @(posedge pixel_clk_in);
        #1 col_valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int b = 0;
        while ((sb.size() != 0 || ray_valid_out) && b < 2000) begin
            @(negedge pixel_clk_in);
            b++;
        end
        @(negedge pixel_clk_in);
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst_n_in       = 1'b0;
        col_valid_in   = 1'b0;
        col_index_in   = '0;
        line_height_in = '0;
        wall_color_in  = '0;
        side_in        = 1'b0;
        col_last_in    = 1'b0;
        repeat (3) @(posedge pixel_clk_in);
        @(negedge pixel_clk_in);
        check_eq("rst_ready", 64'(col_ready_out), 64'd1);
        check_eq("rst_valid", 64'(ray_valid_out), 64'd0);
        check_eq("rst_last",  64'(ray_last_pixel_out), 64'd0);
        check_eq("rst_addr",  64'(ray_address_out), 64'd0);
        check_eq("rst_pix",   64'(ray_pixel_out), 64'd0);
        rst_n_in = 1'b1;

        // Single columns: basic span, clamp, empty span, shading.
        send_col(5,   60,  16'hF800, 1'b0, 1'b0); wait_drain();
        send_col(10,  200, 16'h07E0, 1'b0, 1'b0); wait_drain();
        send_col(100, 0,   16'h1234, 1'b0, 1'b0); wait_drain();
        send_col(33,  60,  16'hF800, 1'b1, 1'b0); wait_drain();
        send_col(200, 91,  16'hFFFF, 1'b1, 1'b0); wait_drain();
        check_eq("idle_ready", 64'(col_ready_out), 64'd1);

        // Back-to-back sweep ending on the last column.
        last_run = 0;
        send_col(0,   100, 16'h001F, 1'b0, 1'b0);
        send_col(319, 120, 16'hABCD, 1'b1, 1'b1);
        wait_drain();
        @(negedge pixel_clk_in);
        check_eq("b2b_run_len", 64'(last_run), 64'd360);
        check_eq("b2b_idle_ready", 64'(col_ready_out), 64'd1);

        // Out-of-range last column: lone pulse one cycle after accept, data held.
        send_col(400, 50, 16'hFFFF, 1'b0, 1'b1);
        @(negedge pixel_clk_in);
        check_eq("oor_t0_last", 64'(ray_last_pixel_out), 64'd0);
        @(negedge pixel_clk_in);
        check_eq("oor_t1_last",  64'(ray_last_pixel_out), 64'd1);
        check_eq("oor_t1_valid", 64'(ray_valid_out), 64'd0);
        check_eq("oor_hold_addr", 64'(ray_address_out), 64'd57599);
        check_eq("oor_hold_pix",  64'(ray_pixel_out), 64'(mdl_pix));
        @(negedge pixel_clk_in);
        check_eq("oor_once", 64'(ray_last_pixel_out), 64'd0);
        send_col(320, 50, 16'hFFFF, 1'b0, 1'b0);
        repeat (4) @(negedge pixel_clk_in);
        check_eq("oor_nolast_valid", 64'(ray_valid_out), 64'd0);
        check_eq("oor_ready", 64'(col_ready_out), 64'd1);

        // Reset in the middle of a last column.
        send_col(7, 100, 16'h5555, 1'b0, 1'b1);
        b = 0;
        while (sb.size() > SH - 51 && b < 1000) begin
            @(negedge pixel_clk_in);
            b++;
        end
        rst_n_in = 1'b0;
        sb.delete();
        mdl_addr = '0;
        mdl_pix  = '0;
        @(posedge pixel_clk_in);
        #1;
        check_eq("mid_rst_valid", 64'(ray_valid_out), 64'd0);
        check_eq("mid_rst_last",  64'(ray_last_pixel_out), 64'd0);
        check_eq("mid_rst_addr",  64'(ray_address_out), 64'd0);
        check_eq("mid_rst_pix",   64'(ray_pixel_out), 64'd0);
        check_eq("mid_rst_ready", 64'(col_ready_out), 64'd1);
        repeat (2) @(negedge pixel_clk_in);
        rst_n_in = 1'b1;
        repeat (200) @(negedge pixel_clk_in);
        check_eq("post_rst_quiet", 64'(sb.size()), 64'd0);
        send_col(12, 60, 16'hF800, 1'b0, 1'b0); wait_drain();

        check_eq("final_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
